avl_mem_arb2: RTL and testbench

- 2:1 Avalon-MM arbiter sharing one Avalon slave port (SDRAM/on-chip memory path of the qsys fabric) between the SCR1 instruction and data AHB-Avalon bridges.
- Round-robin command arbitration, with grant locked for the duration of slave waitrequest.
- Pipelined reads: a tag FIFO of grant IDs routes readdatavalid back to the issuing master in order.

---
 rtl/avl_mem_arb2.sv | 138 +++++++++++++
 tb/tb_avl_mem_arb2.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/avl_mem_arb2.sv
// 2:1 Avalon-MM arbiter: round-robin command grant, locked while the slave stalls,
// with an in-order tag FIFO steering pipelined read returns back to the issuing master.
module avl_mem_arb2 #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            m0_read,
  input  logic            m0_write,
  input  logic [AW-1:0]   m0_address,
  input  logic [DW/8-1:0] m0_byteenable,
  input  logic [DW-1:0]   m0_writedata,
  output logic            m0_waitrequest,
  output logic            m0_readdatavalid,
  output logic [DW-1:0]   m0_readdata,
  output logic [1:0]      m0_response,
  input  logic            m1_read,
  input  logic            m1_write,
  input  logic [AW-1:0]   m1_address,
  input  logic [DW/8-1:0] m1_byteenable,
  input  logic [DW-1:0]   m1_writedata,
  output logic            m1_waitrequest,
  output logic            m1_readdatavalid,
  output logic [DW-1:0]   m1_readdata,
  output logic [1:0]      m1_response,
  output logic            s_read,
  output logic            s_write,
  output logic [AW-1:0]   s_address,
  output logic [DW/8-1:0] s_byteenable,
  output logic [DW-1:0]   s_writedata,
  input  logic            s_waitrequest,
  input  logic            s_readdatavalid,
  input  logic [DW-1:0]   s_readdata,
  input  logic [1:0]      s_response,
  output logic            err_unexp_rdv
);
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                 state, state_nxt;
  logic                   lock_g, lock_g_nxt, last_grant;
  logic                   gnt, fwd, acc, push, pop, head, fifo_full;
  logic [1:0]             rd, wr, req, elig;
  logic [MAX_OUTST-1:0]   tags;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;

  assign rd        = {m1_read, m0_read};
  assign wr        = {m1_write, m0_write};
  assign req       = rd | wr;
  assign fifo_full = (count == CW'(MAX_OUTST));
  // a full tag FIFO only blocks reads; writes keep flowing
  assign elig      = req & ~(rd & {2{fifo_full}});

  always_comb begin
    state_nxt  = state;
    lock_g_nxt = lock_g;
    gnt        = 1'b0;
    fwd        = 1'b0;
    case (state)
      IDLE: begin
        gnt = (elig == 2'b11) ? ~last_grant : elig[1];
        fwd = |elig;
        if (fwd && s_waitrequest) begin
          state_nxt  = LOCKED;
          lock_g_nxt = gnt;
        end
      end
      LOCKED: begin
        gnt = lock_g;
        fwd = req[lock_g];
        if (fwd && !s_waitrequest) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    fwd = fwd & reset_n;
  end

  // read wins over write if a master illegally asserts both
  assign s_read       = fwd & rd[gnt];
  assign s_write      = fwd & wr[gnt] & ~rd[gnt];
  assign s_address    = gnt ? m1_address    : m0_address;
  assign s_byteenable = gnt ? m1_byteenable : m0_byteenable;
  assign s_writedata  = gnt ? m1_writedata  : m0_writedata;

  assign acc            = fwd & ~s_waitrequest;
  assign m0_waitrequest = ~(acc & ~gnt);
  assign m1_waitrequest = ~(acc & gnt);

  assign push = acc & s_read;
  assign pop  = s_readdatavalid & (count != '0);
  assign head = tags[rd_ptr];

  assign m0_readdatavalid = pop & ~head;
  assign m1_readdatavalid = pop & head;
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_response      = s_response;
  assign m1_response      = s_response;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      lock_g     <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state  <= state_nxt;
      lock_g <= lock_g_nxt;
      if (acc) last_grant <= gnt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tags          <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      err_unexp_rdv <= 1'b0;
    end else begin
      if (push) begin
        tags[wr_ptr] <= gnt;
        wr_ptr       <= (wr_ptr == PW'(MAX_OUTST - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(MAX_OUTST - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (s_readdatavalid && count == '0) err_unexp_rdv <= 1'b1;
    end
  end
endmodule

// File: tb/tb_avl_mem_arb2.sv
// Directed bench for avl_mem_arb2: grant order, lock under waitrequest, tag FIFO
// routing/backpressure, unexpected-return flag and async reset.
module tb_avl_mem_arb2;
  localparam int AW = 32, DW = 32;

  logic          clk = 1'b0, reset_n;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [AW-1:0] m0_address, m1_address;
  logic [3:0]    m0_byteenable, m1_byteenable;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic          m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic [1:0]    m0_response, m1_response;
  logic          s_read, s_write, s_waitrequest, s_readdatavalid;
  logic [AW-1:0] s_address;
  logic [3:0]    s_byteenable;
  logic [DW-1:0] s_writedata, s_readdata;
  logic [1:0]    s_response;
  logic          err_unexp_rdv;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  avl_mem_arb2 #(.AW(AW), .DW(DW), .MAX_OUTST(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdatavalid(m0_readdatavalid),
    .m0_readdata(m0_readdata), .m0_response(m0_response),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdatavalid(m1_readdatavalid),
    .m1_readdata(m1_readdata), .m1_response(m1_response),
    .s_read(s_read), .s_write(s_write), .s_address(s_address),
    .s_byteenable(s_byteenable), .s_writedata(s_writedata),
    .s_waitrequest(s_waitrequest), .s_readdatavalid(s_readdatavalid),
    .s_readdata(s_readdata), .s_response(s_response),
    .err_unexp_rdv(err_unexp_rdv)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_address = '0; m1_address = '0; m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_writedata = '0; m1_writedata = '0;
    s_waitrequest = 0; s_readdatavalid = 0; s_readdata = '0; s_response = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    tick();
    reset_n = 1;
    #1;
  endtask

  initial begin
    // reset state
    idle_inputs();
    reset_n = 0;
    m0_read = 1;
    #2;
    chk("rst_s_read", s_read, 0);
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
    chk("rst_err", err_unexp_rdv, 0);
    tick();
    m0_read = 0;
    reset_n = 1;
    tick();

    // single m0 read, return two cycles later
    m0_read = 1; m0_address = 32'h100; #1;
    chk("t1_s_read", s_read, 1);
    chk("t1_s_addr", s_address, 32'h100);
    chk("t1_m0_wait", m0_waitrequest, 0);
    chk("t1_m1_wait", m1_waitrequest, 1);
    tick();
    m0_read = 0;
    tick();
    s_readdatavalid = 1; s_readdata = 32'hDEADBEEF; #1;
    chk("t1_m0_rdv", m0_readdatavalid, 1);
    chk("t1_m0_data", m0_readdata, 32'hDEADBEEF);
    chk("t1_m1_rdv", m1_readdatavalid, 0);
    tick();

    // both masters read continuously: alternate m0,m1,m0,m1 then in-order returns
    do_reset();
    m0_read = 1; m0_address = 32'h10; m1_read = 1; m1_address = 32'h20;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_m0_wait", m0_waitrequest, (k % 2 == 0) ? 0 : 1);
      chk("t2_m1_wait", m1_waitrequest, (k % 2 == 0) ? 1 : 0);
      chk("t2_s_addr", s_address, (k % 2 == 0) ? 32'h10 : 32'h20);
      tick();
    end
    m0_read = 0; m1_read = 0;
    for (int k = 0; k < 4; k++) begin
      s_readdatavalid = 1; s_readdata = 32'h1000 + k; #1;
      chk("t2_ret_m0", m0_readdatavalid, (k % 2 == 0) ? 1 : 0);
      chk("t2_ret_m1", m1_readdatavalid, (k % 2 == 0) ? 0 : 1);
      tick();
    end
    s_readdatavalid = 0;

    // m1 write stalled 3 cycles, m0 waits behind the lock
    do_reset();
    m1_write = 1; m1_address = 32'h200; m1_writedata = 32'hCAFE; s_waitrequest = 1; #1;
    chk("t3_c0_addr", s_address, 32'h200);
    chk("t3_c0_m1_wait", m1_waitrequest, 1);
    tick();
    m0_read = 1; m0_address = 32'h300;
    for (int k = 1; k < 3; k++) begin
      #1;
      chk("t3_lock_addr", s_address, 32'h200);
      chk("t3_lock_s_write", s_write, 1);
      chk("t3_lock_m0_wait", m0_waitrequest, 1);
      chk("t3_lock_m1_wait", m1_waitrequest, 1);
      tick();
    end
    s_waitrequest = 0; #1;
    chk("t3_acc_addr", s_address, 32'h200);
    chk("t3_acc_m1_wait", m1_waitrequest, 0);
    chk("t3_acc_m0_wait", m0_waitrequest, 1);
    tick();
    m1_write = 0; #1;
    chk("t3_next_s_read", s_read, 1);
    chk("t3_next_addr", s_address, 32'h300);
    chk("t3_next_m0_wait", m0_waitrequest, 0);
    tick();
    m0_read = 0;

    // fifo full: 5th m1 read stalls, m0 write goes through, one return unblocks
    do_reset();
    m1_read = 1; m1_address = 32'h40;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t4_fill_m1_wait", m1_waitrequest, 0);
      tick();
    end
    chk("t4_count_full", dut.count, 4);
    m0_write = 1; m0_address = 32'h400; #1;
    chk("t4_m1_stall", m1_waitrequest, 1);
    chk("t4_s_write", s_write, 1);
    chk("t4_s_read", s_read, 0);
    chk("t4_wr_addr", s_address, 32'h400);
    chk("t4_m0_wait", m0_waitrequest, 0);
    tick();
    m0_write = 0; s_readdatavalid = 1; #1;
    chk("t4_ret_m1_rdv", m1_readdatavalid, 1);
    chk("t4_ret_m1_wait", m1_waitrequest, 1);
    tick();
    s_readdatavalid = 0; #1;
    chk("t4_unblk_m1_wait", m1_waitrequest, 0);
    chk("t4_unblk_s_read", s_read, 1);
    tick();
    m1_read = 0;
    chk("t4_count_after", dut.count, 4);

    // push and pop in the same cycle at count 2
    do_reset();
    m0_read = 1; tick(); m0_read = 0;
    m1_read = 1; tick(); m1_read = 0;
    chk("t5_count2", dut.count, 2);
    m0_read = 1; s_readdatavalid = 1; #1;
    chk("t5_pp_m0_rdv", m0_readdatavalid, 1);
    chk("t5_pp_m1_rdv", m1_readdatavalid, 0);
    chk("t5_pp_m0_wait", m0_waitrequest, 0);
    tick();
    m0_read = 0;
    chk("t5_count_hold", dut.count, 2);
    #1;
    chk("t5_p1_m1_rdv", m1_readdatavalid, 1);
    tick();
    #1;
    chk("t5_p2_m0_rdv", m0_readdatavalid, 1);
    tick();
    s_readdatavalid = 0;

    // unexpected return, then async reset with outstanding reads
    do_reset();
    s_readdatavalid = 1; #1;
    chk("t6_unexp_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
    tick();
    s_readdatavalid = 0;
    chk("t6_err_set", err_unexp_rdv, 1);
    m0_read = 1;
    for (int k = 0; k < 3; k++) tick();
    chk("t6_err_sticky", err_unexp_rdv, 1);
    chk("t6_count3", dut.count, 3);
    #2 reset_n = 0; #1;
    chk("t6_rst_count", dut.count, 0);
    chk("t6_rst_err", err_unexp_rdv, 0);
    chk("t6_rst_s_read", s_read, 0);
    chk("t6_rst_m0_wait", m0_waitrequest, 1);
    tick();
    m0_read = 0; reset_n = 1;
    s_readdatavalid = 1; #1;
    chk("t6_late_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
    tick();
    s_readdatavalid = 0;
    chk("t6_late_err", err_unexp_rdv, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
